button_conditioner: RTL and testbench

Front-end conditioning stage between the board push-buttons and the board-level debug top.
- Synchronises, debounces and edge-detects every push-button.
- Produces clean single-cycle step pulses for the single-stepped CPU clock domain.
- Maintains the display view-select counter that cycles through CPU debug values.
- Downstream logic consumes only clean levels and pulses; nothing clocks on raw button pins.

---
 rtl/button_pkg.sv | 25 ++
 rtl/debounce_cell.sv | 63 ++++++
 rtl/button_conditioner.sv | 110 +++++++++++
 tb/tb_button_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and debug view indices for button_conditioner
//   STEP_CNT_W            width of the step event counter
//   DEF_DEBOUNCE_CYCLES   20 ms at 100 MHz
//   DEF_HOLD_CYCLES       500 ms at 100 MHz (auto-repeat start delay)
//   DEF_REPEAT_CYCLES     100 ms at 100 MHz (auto-repeat period)
//   view_e                display view indices for the CPU debug values
package button_pkg;

    localparam int STEP_CNT_W          = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEF_HOLD_CYCLES     = 50_000_000;
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;

    typedef enum logic [2:0] {
        VIEW_BANNER = 3'd0,
        VIEW_IR     = 3'd1,
        VIEW_A      = 3'd2,
        VIEW_B      = 3'd3,
        VIEW_C      = 3'd4,
        VIEW_F      = 3'd5,
        VIEW_SHIFT  = 3'd6,
        VIEW_WDATA  = 3'd7
    } view_e;

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - synchroniser, debounce counter and edge pulses for one button
//   clk    board clock
//   rst    asynchronous reset, active-low
//   pin    raw asynchronous button pin
//   level  debounced level
//   rise   one-cycle pulse when level goes 0 -> 1
//   fall   one-cycle pulse when level goes 1 -> 0
module debounce_cell
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          s;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= pin;
            s    <= meta;
        end
    end

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept = (s != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            // Any sample matching the current level restarts the count.
            if (s == level || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                level <= s;
            end
            rise <= accept &  s;
            fall <= accept & ~s;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button conditioning, step pulses and view select
//   clk         board clock
//   rst         asynchronous reset, active-low
//   btn_raw     raw push-button pins
//   btn_level   debounced levels
//   btn_rise    one-cycle press pulses
//   btn_fall    one-cycle release pulses
//   step_pulse  one-cycle CPU step enable
//   step_count  step_pulse events since reset (wraps)
//   view_sel    display view index (wraps at VIEW_COUNT-1)
// Optional: BTN_AUTO_REPEAT_EN adds hold-to-repeat step pulses on STEP_BTN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = 6,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int VIEW_COUNT      = 8,
    parameter int VIEW_BTN        = 5,
    parameter int STEP_BTN        = 1,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_raw,
    output logic [N_BTN-1:0]              btn_level,
    output logic [N_BTN-1:0]              btn_rise,
    output logic [N_BTN-1:0]              btn_fall,
    output logic                          step_pulse,
    output logic [STEP_CNT_W-1:0]         step_count,
    output logic [$clog2(VIEW_COUNT)-1:0] view_sel
);

    localparam int VW = $clog2(VIEW_COUNT);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .pin  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int            HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_AT = HW'(HOLD_CYCLES);
    // After each pulse the timer is rewound so it reaches HOLD_AT again
    // REPEAT_CYCLES later; this assumes REPEAT_CYCLES <= HOLD_CYCLES.
    localparam logic [HW-1:0] RELOAD  = HW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic [HW-1:0] hold_timer;
    logic          repeat_pulse;

    // hold_timer holds the number of cycles since the rise while the button stays down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_timer <= '0;
        end else if (!btn_level[STEP_BTN] || btn_fall[STEP_BTN]) begin
            hold_timer <= '0;
        end else if (hold_timer == HOLD_AT) begin
            hold_timer <= RELOAD;
        end else begin
            hold_timer <= hold_timer + 1'b1;
        end
    end

    // Gating with the level suppresses a pulse in the cycle the release is accepted.
    assign repeat_pulse = btn_level[STEP_BTN] && (hold_timer == HOLD_AT);
    assign step_pulse   = btn_rise[STEP_BTN] | repeat_pulse;
`else
    logic unused_repeat_cfg;

    assign unused_repeat_cfg = (HOLD_CYCLES != 0) ^ (REPEAT_CYCLES != 0);
    assign step_pulse        = btn_rise[STEP_BTN];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_count <= '0;
        end else if (step_pulse) begin
            step_count <= step_count + 1'b1;
        end
    end

    if ((VIEW_COUNT & (VIEW_COUNT - 1)) == 0) begin : g_view_pow2
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                view_sel <= '0;
            end else if (btn_rise[VIEW_BTN]) begin
                view_sel <= view_sel + 1'b1;
            end
        end
    end else begin : g_view_cmp
        localparam logic [VW-1:0] VIEW_LAST = VW'(VIEW_COUNT - 1);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                view_sel <= '0;
            end else if (btn_rise[VIEW_BTN]) begin
                view_sel <= (view_sel == VIEW_LAST) ? '0 : view_sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

    localparam int N_BTN      = 6;
    localparam int DEB        = 4;
    localparam int VIEW_COUNT = 8;
    localparam int VIEW_BTN   = 5;
    localparam int STEP_BTN   = 1;
    localparam int HOLD       = 20;
    localparam int REPEAT     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic             step_pulse;
    logic [15:0]      step_count;
    logic [2:0]       view_sel;

    button_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .VIEW_COUNT     (VIEW_COUNT),
        .VIEW_BTN       (VIEW_BTN),
        .STEP_BTN       (STEP_BTN),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REPEAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .step_pulse(step_pulse),
        .step_count(step_count),
        .view_sel  (view_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int edge_no;
        int btn;
        bit up;
    } evt_t;

    int               edge_n = 0;
    logic [N_BTN-1:0] samples[$];
    logic [N_BTN-1:0] m_level;
    int               last_flip[N_BTN];
    int               step_rise_edge;
    evt_t             evt_q[$];
    int               step_q[$];
    int               m_step_cnt;
    int               m_view;
    bit               step_prev;
    bit               view_prev;

    // A level flips once the pin, seen two edges late, has differed from it for
    // DEB consecutive edges, all later than the previous flip.
    always @(posedge clk or negedge rst) begin
        int   r;
        int   e;
        bit   flip;
        bit   step_now;
        bit   view_now;
        evt_t ev;
        if (!rst) begin
            samples.delete();
            m_level = '0;
            foreach (last_flip[b]) last_flip[b] = 0;
            step_rise_edge = 0;
            m_step_cnt = 0;
            m_view = 0;
            step_prev = 0;
            view_prev = 0;
        end else begin
            edge_n++;
            if (step_prev) m_step_cnt = (m_step_cnt + 1) % 65536;
            if (view_prev) m_view = (m_view + 1) % VIEW_COUNT;
            samples.push_back(btn_raw);
            r = samples.size();
            step_now = 0;
            view_now = 0;
            for (int b = 0; b < N_BTN; b++) begin
                flip = 1;
                for (int j = 0; j < DEB; j++) begin
                    e = r - j;
                    if (e <= last_flip[b] || e < 3) flip = 0;
                    else if (samples[e-3][b] == m_level[b]) flip = 0;
                end
                if (flip) begin
                    m_level[b] = ~m_level[b];
                    last_flip[b] = r;
                    ev.edge_no = edge_n;
                    ev.btn = b;
                    ev.up = m_level[b];
                    evt_q.push_back(ev);
                    if (m_level[b] && b == VIEW_BTN) view_now = 1;
                    if (m_level[b] && b == STEP_BTN) begin
                        step_now = 1;
                        step_rise_edge = r;
                    end
                end
            end
`ifdef BTN_AUTO_REPEAT_EN
            if (m_level[STEP_BTN] && !step_now && (r - step_rise_edge) >= HOLD &&
                ((r - step_rise_edge - HOLD) % REPEAT) == 0) step_now = 1;
`endif
            if (step_now) step_q.push_back(edge_n);
            step_prev = step_now;
            view_prev = view_now;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [N_BTN-1:0] er;
        logic [N_BTN-1:0] ef;
        bit               es;
        er = '0;
        ef = '0;
        es = 0;
        while (evt_q.size() > 0 && evt_q[0].edge_no <= edge_n) begin
            if (evt_q[0].up) er[evt_q[0].btn] = 1'b1;
            else ef[evt_q[0].btn] = 1'b1;
            void'(evt_q.pop_front());
        end
        while (step_q.size() > 0 && step_q[0] <= edge_n) begin
            es = 1;
            void'(step_q.pop_front());
        end
        check("btn_rise", 32'(btn_rise), 32'(er));
        check("btn_fall", 32'(btn_fall), 32'(ef));
        check("rise_fall_overlap", 32'(btn_rise & btn_fall), 32'd0);
        check("step_pulse", 32'(step_pulse), 32'(es));
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("step_count", 32'(step_count), 32'(m_step_cnt));
        check("view_sel", 32'(view_sel), 32'(m_view));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        cyc(1);
        rst = 1'b0;
        btn_raw = '0;
        cyc(2);
        rst = 1'b1;
    endtask

    // Returns the edge (1-based) at which btn_level[b] first equals val, 0 if never.
    task automatic wait_level(input int b, input logic val, input int limit,
                              output int first, output int rises, output int falls);
        first = 0;
        rises = 0;
        falls = 0;
        for (int i = 1; i <= limit; i++) begin
            cyc(1);
            if (first == 0 && btn_level[b] == val) first = i;
            rises += int'(btn_rise[b]);
            falls += int'(btn_fall[b]);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int rises;
        int falls;
        int steps;
        int left[N_BTN];

        // Reset with pins high: level stays 0.
        btn_raw = '1;
        cyc(3);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_step_count", 32'(step_count), 32'd0);
        btn_raw = '0;
        cyc(1);
        rst = 1'b1;

        // Latency from a clean press.
        btn_raw[1] = 1'b1;
        wait_level(1, 1'b1, 10, first, rises, falls);
        check("latency_edge", 32'(first), 32'(DEB + 2));
        check("latency_rises", 32'(rises), 32'd1);
        check("latency_step_count", 32'(step_count), 32'd1);
        btn_raw[1] = 1'b0;
        cyc(10);

        // Bounce shorter than the debounce window.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            cyc(2);
        end
        btn_raw[1] = 1'b0;
        wait_level(1, 1'b1, 12, first, rises, falls);
        check("bounce_rises", 32'(rises), 32'd0);
        check("bounce_step_count", 32'(step_count), 32'd0);

        // View select wraps through all views.
        do_reset();
        for (int p = 0; p < 9; p++) begin
            btn_raw[VIEW_BTN] = 1'b1;
            cyc(8);
            btn_raw[VIEW_BTN] = 1'b0;
            cyc(8);
            check($sformatf("view_after_press_%0d", p + 1), 32'(view_sel), 32'((p + 1) % VIEW_COUNT));
        end

        // Release latency.
        btn_raw[3] = 1'b1;
        cyc(10);
        btn_raw[3] = 1'b0;
        wait_level(3, 1'b0, 10, first, rises, falls);
        check("release_edge", 32'(first), 32'(DEB + 2));
        check("release_falls", 32'(falls), 32'd1);
        check("release_rises", 32'(rises), 32'd0);

        // Asynchronous reset in the middle of a debounce.
        btn_raw[1] = 1'b1;
        cyc(10);
        btn_raw[1] = 1'b0;
        cyc(10);
        btn_raw[2] = 1'b1;
        cyc(3);
        rst = 1'b0;
        #1;
        check("async_level", 32'(btn_level), 32'd0);
        check("async_rise", 32'(btn_rise), 32'd0);
        check("async_fall", 32'(btn_fall), 32'd0);
        check("async_step_pulse", 32'(step_pulse), 32'd0);
        check("async_step_count", 32'(step_count), 32'd0);
        check("async_view_sel", 32'(view_sel), 32'd0);
        cyc(2);
        rst = 1'b1;
        wait_level(2, 1'b1, 10, first, rises, falls);
        check("post_reset_edge", 32'(first), 32'(DEB + 2));
        check("post_reset_rises", 32'(rises), 32'd1);
        btn_raw[2] = 1'b0;
        cyc(10);

        // Hold the step button for 40 cycles.
        do_reset();
        steps = 0;
        btn_raw[STEP_BTN] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 40) btn_raw[STEP_BTN] = 1'b0;
            cyc(1);
            steps += int'(step_pulse);
        end
`ifdef BTN_AUTO_REPEAT_EN
        check("hold_steps", 32'(steps), 32'd5);
        check("hold_step_count", 32'(step_count), 32'd5);
`else
        check("hold_steps", 32'(steps), 32'd1);
        check("hold_step_count", 32'(step_count), 32'd1);
`endif

        // Randomised pins, including pulses shorter than the window.
        do_reset();
        foreach (left[b]) left[b] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if (left[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    left[b] = int'($urandom_range(1, 3 * DEB));
                end else begin
                    left[b]--;
                end
            end
            cyc(1);
        end
        btn_raw = '0;
        cyc(20);
        check("evt_q_drained", 32'(evt_q.size()), 32'd0);
        check("step_q_drained", 32'(step_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
